mysystem_onchip_memory_burst: RTL and testbench
===============================================

# mysystem_onchip_memory_burst

Parametrised on-chip RAM Avalon-MM slave for the Qsys system, replacing fixed single-beat on-chip memories. Adds configurable data/address width, a pipelined read path with `readdatavalid`, an optional output register, and read/write bursts with sequential address generation. It sits on the system interconnect as a burst-capable slave, typically serving frame or buffer storage to the HPS bridge and DMA masters.

## Interface
- `DATA_WIDTH`, 16: word width; multiple of 8.
- `ADDR_WIDTH`, 18: word address width.
- `DEPTH`, 165000: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `BURST_WIDTH`, 4: `burstcount` width; MAX_BURST = 2^(BURST_WIDTH-1).
- `OUTPUT_REG`, 0: 0 gives read latency 1; 1 gives read latency 2.
- `INIT_FILE`, "mysystem_onchip_memory_burst.hex": RAM initialisation file.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `reset_req`  in  1  freeze request; 1 blocks all activity.
- `clken`  in  1  clock enable; 0 blocks all activity.
- `chipselect`  in  1  slave select.
- `address`  in  ADDR_WIDTH  word address of the first beat.
- `byteenable`  in  DATA_WIDTH/8  per-byte write enable.
- `read`  in  1  read request.
- `write`  in  1  write request / write beat.
- `writedata`  in  DATA_WIDTH  write data.
- `burstcount`  in  BURST_WIDTH  beats in the burst.
- `waitrequest`  out  1  command/beat not accepted.
- `readdata`  out  DATA_WIDTH  read data.
- `readdatavalid`  out  1  `readdata` holds a valid beat.

## Operation
- `en = clken & ~reset_req`.
- When `en` is 0:
  - state, counters, RAM and the read pipeline all hold;
  - `waitrequest` is forced to 1;
  - `readdatavalid` is forced to 0, and pending beats emerge once `en` returns to 1.
- The FSM has three states: IDLE, RBURST and WBURST.
- Burst length N = `burstcount`, with 0 treated as 1 and values above MAX_BURST clamped to MAX_BURST.
- IDLE:
  - `waitrequest` is 0.
  - A command is accepted when `chipselect` and `en` are both 1.
  - `write` has priority; a `read` asserted together with `write` is dropped.
- Read accept:
  - Beat 0 is issued at `address` in the accept cycle.
  - If N > 1, the FSM enters RBURST with `remaining = N-1`.
- RBURST:
  - `waitrequest` is 1.
  - One beat is issued per `en` cycle at the next sequential address.
  - When the last beat is issued, the FSM returns to IDLE; `waitrequest` drops in the following cycle.
- Write accept:
  - Beat 0 is written at `address` with `byteenable`.
  - If N > 1, the FSM enters WBURST with `remaining = N-1`.
- WBURST:
  - `waitrequest` is 0.
  - Each cycle with `write & chipselect & en` writes the next sequential address.
  - Cycles with `write` at 0 are idle beats and do not advance the counter.
  - `read` is ignored.
  - After the last beat, the FSM returns to IDLE.
- Address arithmetic:
  - The beat address is the base address plus the beat index, computed in ADDR_WIDTH+1 bits.
  - The address wraps to 0 past DEPTH-1.
- Out-of-range start address (`address` ≥ DEPTH):
  - writes are discarded but the burst is still counted;
  - reads return 0 with `readdatavalid` still asserted.
- Byte lanes without `byteenable` keep their prior content.
- Reads and writes never issue in the same cycle, so there is no read-during-write hazard.

## Timing
- Read latency is 1 + OUTPUT_REG enabled cycles from beat issue to `readdatavalid`.
- Throughput is one beat per enabled cycle.
- A burst of N beats:
  - `readdatavalid` is high for N consecutive cycles when `en` stays 1;
  - the first beat appears 1 + OUTPUT_REG cycles after accept.
- A new command may be accepted in the cycle after RBURST ends. Its data follows the previous burst's data back-to-back, with no gap.
- Reset:
  - state goes to IDLE; counters and the pipeline are cleared;
  - `readdata` is 0 and `readdatavalid` is 0;
  - `waitrequest` is 1 while `reset` is high and 0 in the first cycle after.
- Reset mid-burst abandons the burst and drops in-flight beats (no `readdatavalid` afterwards). RAM contents are retained.

## Test plan
- Single-beat write then read, with OUTPUT_REG=0:
  - write 0xBEEF to address 5, then read 5 with burstcount 1;
  - required: `readdatavalid` exactly 1 cycle after accept with data 0xBEEF.
- Partial write:
  - write 0x1234 to address 7, then write 0xAB00 with byteenable=2'b10;
  - required: a read of address 7 returns 0xAB34.
- Read burst of 8 from address 100, preloaded with 100+i, OUTPUT_REG=1:
  - required: `waitrequest` high for 7 cycles after accept;
  - required: 8 consecutive valid beats 100..107, first one 2 cycles after accept.
- Write burst of 4 at address DEPTH-2, with a `write`=0 gap after beat 1:
  - required: data lands at DEPTH-2, DEPTH-1, 0 and 1;
  - required: the FSM returns to IDLE only after the 4th beat.
- Freeze and reset during a read burst:
  - pull `clken` low for 3 cycles mid-burst: the beat stream pauses and resumes with no data lost;
  - assert `reset` mid-burst: `readdatavalid` is 0 afterwards and `waitrequest` is 0 in the first cycle after `reset` falls.

Source files
------------

// File: rtl/mysystem_onchip_memory_burst.sv
// mysystem_onchip_memory_burst: burst-capable Avalon-MM on-chip RAM slave.
// Pipelined reads (latency 1 + OUTPUT_REG), sequential wrapping burst addresses.
// Ports: clk, reset (sync, active-high), reset_req/clken (freeze when en=0),
//   Avalon-MM slave: chipselect, address, byteenable, read, write, writedata,
//   burstcount, waitrequest, readdata, readdatavalid.
module mysystem_onchip_memory_burst #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 18,
  parameter int DEPTH       = 165000,
  parameter int BURST_WIDTH = 4,
  parameter int OUTPUT_REG  = 0,
  parameter     INIT_FILE   = "mysystem_onchip_memory_burst.hex"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_req,
  input  logic                      clken,
  input  logic                      chipselect,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic [BURST_WIDTH-1:0]    burstcount,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int MAX_BURST = 1 << (BURST_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [BURST_WIDTH-1:0] MAX_B = BURST_WIDTH'(MAX_BURST);
  localparam logic [BURST_WIDTH-1:0] ONE_B = BURST_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RBURST,
    WBURST
  } state_e;

  // The image named by INIT_FILE is loaded by the memory build flow,
  // not by this RTL; the reduction only keeps the name attached.
  logic unused_init;
  assign unused_init = ^INIT_FILE;

  state_e                  state_q, state_d;
  logic [BURST_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    oor_q, oor_d;
  logic                    s1_vld_q, s1_vld_d;

  logic                    en;
  logic [BURST_WIDTH-1:0]  blen;
  logic                    start_oor;
  logic                    rd_issue;
  logic                    wr_issue;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    beat_zero;
  logic                    out_vld;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_q;

  assign en = clken & ~reset_req;

  // Next sequential beat address, wrapping past the last word.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, a} + (ADDR_WIDTH + 1)'(1);
    if (s >= DEPTH_W) s = '0;
    return s[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    blen = burstcount;
    if (burstcount == '0) begin
      blen = ONE_B;
    end else if (burstcount > MAX_B) begin
      blen = MAX_B;
    end
  end

  assign start_oor = ({1'b0, address} >= DEPTH_W);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    oor_d       = oor_q;
    rd_issue    = 1'b0;
    wr_issue    = 1'b0;
    beat_addr   = addr_q;
    beat_zero   = oor_q;
    unique case (state_q)
      IDLE: begin
        beat_addr = address;
        beat_zero = start_oor;
        if (en && chipselect && write) begin
          wr_issue = 1'b1;
          addr_d   = addr_inc(address);
          oor_d    = start_oor;
          if (blen != ONE_B) begin
            state_d     = WBURST;
            remaining_d = blen - ONE_B;
          end
        end else if (en && chipselect && read) begin
          rd_issue = 1'b1;
          addr_d   = addr_inc(address);
          oor_d    = start_oor;
          if (blen != ONE_B) begin
            state_d     = RBURST;
            remaining_d = blen - ONE_B;
          end
        end
      end
      RBURST: begin
        if (en) begin
          rd_issue    = 1'b1;
          addr_d      = addr_inc(addr_q);
          remaining_d = remaining_q - ONE_B;
          if (remaining_q == ONE_B) state_d = IDLE;
        end
      end
      WBURST: begin
        // Cycles without write are idle beats and do not advance.
        if (en && chipselect && write) begin
          wr_issue    = 1'b1;
          addr_d      = addr_inc(addr_q);
          remaining_d = remaining_q - ONE_B;
          if (remaining_q == ONE_B) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-data-valid pipeline stage aligned with the RAM output register.
  always_comb begin
    s1_vld_d = s1_vld_q;
    if (en) s1_vld_d = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      s1_vld_q    <= s1_vld_d;
    end
  end

  // Byte-lane write port; out-of-range bursts are counted but discarded.
  always_ff @(posedge clk) begin
    if (wr_issue && !beat_zero && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) begin
          mem[beat_addr][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  // Registered RAM read port; out-of-range beats read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_q <= '0;
    end else if (rd_issue) begin
      ram_q <= beat_zero ? '0 : mem[beat_addr];
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  s2_vld_q, s2_vld_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_data_d = s2_data_q;
      if (en) begin
        s2_vld_d  = s1_vld_q;
        s2_data_d = ram_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q  <= s2_vld_d;
        s2_data_q <= s2_data_d;
      end
    end

    assign out_vld  = s2_vld_q;
    assign readdata = s2_data_q;
  end else begin : g_noreg
    assign out_vld  = s1_vld_q;
    assign readdata = ram_q;
  end

  // Held beats stay in the pipe while frozen and emerge when en returns.
  assign readdatavalid = out_vld & en & ~reset;
  assign waitrequest   = reset | ~en | (state_q == RBURST);

endmodule

// File: tb/tb_mysystem_onchip_memory_burst.sv
// tb_mysystem_onchip_memory_burst: directed + random checks of the burst RAM
// slave, with OUTPUT_REG=0 and OUTPUT_REG=1 instances driven in parallel.
module tb_mysystem_onchip_memory_burst;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int DEPTH = 165000;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset_req, clken, chipselect, read, write;
  logic [AW-1:0] address;
  logic [1:0]    byteenable;
  logic [DW-1:0] writedata;
  logic [BW-1:0] burstcount;
  logic          wr0, wr1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;

  mysystem_onchip_memory_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .BURST_WIDTH(BW), .OUTPUT_REG(0)
  ) dut0 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .burstcount(burstcount), .waitrequest(wr0), .readdata(rd0),
    .readdatavalid(rv0)
  );

  mysystem_onchip_memory_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .BURST_WIDTH(BW), .OUTPUT_REG(1)
  ) dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .burstcount(burstcount), .waitrequest(wr1), .readdata(rd1),
    .readdatavalid(rv1)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } beat_t;

  beat_t         obs0[$], obs1[$];
  logic [DW-1:0] exp0[$], exp1[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] wd [8];
  logic [1:0]    wbe [8];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            rand_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rv0) obs0.push_back('{rd0, cyc});
    if (rv1) obs1.push_back('{rd1, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int blen(input int bc);
    if (bc == 0) return 1;
    if (bc > 8) return 8;
    return bc;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a0, input int i);
    int a;
    if (a0 >= DEPTH) return '0;
    a = (a0 + i) % DEPTH;
    if (!ref_mem.exists(a)) return 'x;
    return ref_mem[a];
  endfunction

  function automatic void model_write(input int a0, input int i,
                                      input logic [DW-1:0] d,
                                      input logic [1:0] be);
    int a;
    logic [DW-1:0] v;
    if (a0 >= DEPTH) return;
    a = (a0 + i) % DEPTH;
    v = ref_mem.exists(a) ? ref_mem[a] : '0;
    if (be[0]) v[7:0] = d[7:0];
    if (be[1]) v[15:8] = d[15:8];
    ref_mem[a] = v;
  endfunction

  // One bus cycle; acc reports that waitrequest was low before the edge.
  task automatic cyc_drive(input bit cs, input bit rd, input bit wr,
                           input int a, input logic [DW-1:0] d,
                           input logic [1:0] be, input int bc,
                           output bit acc, output int stamp);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = AW'(a);
    writedata  = d;
    byteenable = be;
    burstcount = BW'(bc);
    if (rand_en) begin
      clken     = ($urandom_range(0, 4) != 0);
      reset_req = ($urandom_range(0, 9) == 0);
    end
    #1;
    acc   = !wr0;
    stamp = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    int st;
    for (int k = 0; k < n; k++) cyc_drive(0, 0, 0, 0, '0, 2'b00, 1, acc, st);
  endtask

  task automatic rd_cmd(input int a, input int bc, output int stamp);
    bit acc;
    int st;
    acc = 0;
    st  = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      cyc_drive(1, 1, 0, a, '0, 2'b00, bc, acc, st);
    end
    stamp = st;
    if (acc) begin
      for (int i = 0; i < blen(bc); i++) begin
        exp0.push_back(ref_rd(a, i));
        exp1.push_back(ref_rd(a, i));
      end
    end else begin
      chk("rd_accept_timeout", 0, 1);
    end
  endtask

  // Write burst; the gap cycle before beat gap_at drives write=0, read=1.
  task automatic wr_burst(input int a, input int bc, input int gap_at);
    bit acc;
    bit gap_done;
    int st;
    int i;
    int t;
    i = 0;
    t = 0;
    gap_done = 0;
    while (i < blen(bc) && t < 300) begin
      if (i == gap_at && !gap_done) begin
        cyc_drive(1, 1, 0, 100, '0, 2'b00, 1, acc, st);
        gap_done = 1;
      end else begin
        cyc_drive(1, 0, 1, a, wd[i], wbe[i], bc, acc, st);
        if (acc) begin
          model_write(a, i, wd[i], wbe[i]);
          i++;
        end
      end
      t++;
    end
    if (i < blen(bc)) chk("wr_burst_timeout", i, blen(bc));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((obs0.size() < exp0.size() || obs1.size() < exp1.size())
           && n < 500) begin
      idle(1);
      n++;
    end
    idle(4);
    chk({tag, "_cnt0"}, obs0.size(), exp0.size());
    chk({tag, "_cnt1"}, obs1.size(), exp1.size());
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++)
      chk($sformatf("%s_d0[%0d]", tag, i), obs0[i].d, exp0[i]);
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++)
      chk($sformatf("%s_d1[%0d]", tag, i), obs1[i].d, exp1[i]);
  endtask

  task automatic flush();
    obs0.delete();
    obs1.delete();
    exp0.delete();
    exp1.delete();
  endtask

  function automatic int c0(input int i);
    return (obs0.size() > i) ? obs0[i].c : -1000;
  endfunction

  function automatic int c1(input int i);
    return (obs1.size() > i) ? obs1[i].c : -1000;
  endfunction

  function automatic logic [DW-1:0] d0(input int i);
    return (obs0.size() > i) ? obs0[i].d : 'x;
  endfunction

  initial begin
    int  st;
    int  st2;
    bit  acc;
    int  op;
    int  a;
    int  bc;
    int  n;

    reset      = 1;
    reset_req  = 0;
    clken      = 1;
    chipselect = 0;
    read       = 0;
    write      = 0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    burstcount = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait0", wr0, 1);
    chk("rst_wait1", wr1, 1);
    chk("rst_rdv0", rv0, 0);
    chk("rst_rdv1", rv1, 0);
    chk("rst_data0", rd0, 0);
    chk("rst_data1", rd1, 0);
    reset = 0;
    #1;
    chk("post_rst_wait0", wr0, 0);
    chk("post_rst_wait1", wr1, 0);

    // Single-beat write then read.
    wd[0] = 16'hBEEF;
    wbe[0] = 2'b11;
    wr_burst(5, 1, -1);
    rd_cmd(5, 1, st);
    drain("single");
    chk("single_val", d0(0), 16'hBEEF);
    chk("single_lat0", c0(0) - st, 1);
    chk("single_lat1", c1(0) - st, 2);
    flush();

    // Partial write keeps the disabled lane.
    wd[0] = 16'h1234;
    wbe[0] = 2'b11;
    wr_burst(7, 1, -1);
    wd[0] = 16'hAB00;
    wbe[0] = 2'b10;
    wr_burst(7, 1, -1);
    rd_cmd(7, 1, st);
    drain("partial");
    chk("partial_val", d0(0), 16'hAB34);
    flush();

    // Read burst of 8 from preloaded 100..107.
    for (int i = 0; i < 8; i++) begin
      wd[i] = 16'(100 + i);
      wbe[i] = 2'b11;
    end
    wr_burst(100, 8, -1);
    rd_cmd(100, 8, st);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rb_wait[%0d]", i), wr0, 1);
      idle(1);
    end
    chk("rb_wait_end", wr0, 0);
    drain("rburst");
    chk("rb_lat0", c0(0) - st, 1);
    chk("rb_lat1", c1(0) - st, 2);
    chk("rb_span0", c0(7) - c0(0), 7);
    chk("rb_span1", c1(7) - c1(0), 7);
    chk("rb_last", d0(7), 16'd107);
    flush();

    // Wrapping write burst with an idle (read-asserted) beat after beat 1.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 16'hA000 + 16'(i);
      wbe[i] = 2'b11;
    end
    wr_burst(DEPTH - 2, 4, 2);
    rd_cmd(DEPTH - 2, 4, st);
    rd_cmd(0, 1, st);
    rd_cmd(1, 1, st);
    drain("wrap");
    chk("wrap_a0", d0(2), 16'hA002);
    chk("wrap_a1", d0(5), 16'hA003);
    flush();

    // Freeze mid-burst: stream pauses 3 cycles, nothing lost.
    rd_cmd(100, 8, st);
    idle(2);
    clken = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("frz_rdv0[%0d]", i), rv0, 0);
      chk($sformatf("frz_rdv1[%0d]", i), rv1, 0);
      chk($sformatf("frz_wait[%0d]", i), wr0, 1);
      idle(1);
    end
    clken = 1;
    drain("freeze");
    chk("frz_span0", c0(7) - c0(0), 10);
    chk("frz_span1", c1(7) - c1(0), 10);
    flush();

    // Reset mid-burst drops in-flight beats.
    rd_cmd(100, 8, st);
    idle(2);
    reset = 1;
    idle(1);
    chk("mrst_rdv0", rv0, 0);
    chk("mrst_rdv1", rv1, 0);
    chk("mrst_data0", rd0, 0);
    chk("mrst_data1", rd1, 0);
    chk("mrst_wait", wr0, 1);
    idle(1);
    reset = 0;
    #1;
    chk("mrst_post_wait0", wr0, 0);
    chk("mrst_post_wait1", wr1, 0);
    idle(10);
    while (exp0.size() > 2) void'(exp0.pop_back());
    while (exp1.size() > 1) void'(exp1.pop_back());
    drain("midrst");
    flush();

    // Write wins over a simultaneous read.
    cyc_drive(1, 1, 1, 9, 16'h5A5A, 2'b11, 1, acc, st);
    if (acc) model_write(9, 0, 16'h5A5A, 2'b11);
    chk("prio_acc", acc, 1);
    idle(1);
    rd_cmd(9, 1, st);
    drain("prio");
    chk("prio_val", d0(0), 16'h5A5A);
    flush();

    // Out-of-range start addresses.
    rd_cmd(DEPTH + 3, 2, st);
    for (int i = 0; i < 3; i++) begin
      wd[i] = 16'hDEAD;
      wbe[i] = 2'b11;
    end
    wr_burst(DEPTH + 1, 3, -1);
    rd_cmd(0, 2, st);
    drain("oor");
    chk("oor_zero", d0(1), 16'h0000);
    flush();

    // Back-to-back bursts stream with no gap.
    rd_cmd(100, 4, st);
    rd_cmd(104, 4, st2);
    drain("b2b");
    chk("b2b_acc_gap", st2 - st, 4);
    chk("b2b_span0", c0(7) - c0(0), 7);
    chk("b2b_span1", c1(7) - c1(0), 7);
    flush();

    // Randomised traffic with random clken/reset_req.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        wd[i] = 16'($urandom);
        wbe[i] = 2'b11;
      end
      wr_burst(r * 8, 8, -1);
    end
    for (int i = 0; i < 8; i++) begin
      wd[i] = 16'($urandom);
      wbe[i] = 2'b11;
    end
    wr_burst(DEPTH - 8, 8, -1);
    rand_en = 1;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 1) ? $urandom_range(0, 55)
                                : DEPTH - 8 + $urandom_range(0, 7);
      if (op >= 8) a = DEPTH + $urandom_range(0, (1 << AW) - 1 - DEPTH);
      bc = $urandom_range(0, 15);
      n  = blen(bc);
      if (op < 4 || op == 8) begin
        rd_cmd(a, bc, st);
      end else begin
        for (int i = 0; i < 8; i++) begin
          wd[i] = 16'($urandom);
          wbe[i] = 2'($urandom);
        end
        wr_burst(a, bc, (n > 1 && $urandom_range(0, 1) == 1)
                        ? $urandom_range(1, n - 1) : -1);
      end
    end
    rand_en   = 0;
    clken     = 1;
    reset_req = 0;
    drain("rand");
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
